vga_tile_renderer: RTL
======================

Name: vga_tile_renderer

Overview:
- Sits directly downstream of VGA_CTRL and drives the board R/G/B and sync pins.
- Maps each active pixel (col,row) onto a 20x15 grid of 32x32 superpixel tiles and issues a read to the tile memory (VGA_memory, synchronous, 1-cycle read).
- Decodes the returned 9-bit tile word into a pixel colour, with pattern and blink attributes.
- Delays hsync/vsync so they stay aligned with the colour output.

Parameters:
- BASE_ADDR, 12'd0, tile-map start address in VGA_memory
- ADDR_W, 12, memory address width
- BLINK_FRAMES, 30, frames per blink half-period; must be ≥ 1
- SYNC_IDLE, 1'b1, inactive level of hsync/vsync (syncs are active-low)

Ports:
- clk  in  1  50 MHz system clock; same clock as VGA_CTRL Clk50
- reset  in  1  asynchronous, active-low reset
- col  in  10  pixel column from VGA_CTRL
- row  in  9  pixel row from VGA_CTRL
- active  in  1  visible-region flag from VGA_CTRL
- hsync_in  in  1  raw hsync from VGA_CTRL
- vsync_in  in  1  raw vsync from VGA_CTRL
- mem_addr  out  ADDR_W  tile-memory read address
- mem_data  in  9  tile word; valid one clk after mem_addr
- R  out  1  red
- G  out  1  green
- B  out  1  blue
- hSync  out  1  aligned hsync
- vSync  out  1  aligned vsync

Behaviour:
- Pipeline runs on every clk; there is no enable. All inputs are sampled every clk.
- S1 (registered):
  - tx = col[9:5] (0..19), ty = row[8:5] (0..14).
  - mem_addr <= BASE_ADDR + ty*20 + tx, computed as (ty<<4)+(ty<<2)+tx, zero-extended to ADDR_W; the maximum offset is 299.
  - S1 also registers active, lx = col[4:0], ly = row[4:0], and both syncs.
  - If active=0, or col≥640, or row≥480: mem_addr holds its previous value and the S1 valid bit = 0.
- S2: mem_data returns; lx, ly, valid and syncs are delayed one more stage.
- S3 (registered): colour decode drives R/G/B; hSync/vSync are the 3-stage-delayed syncs.
- Total latency from input to R/G/B/hSync/vSync is exactly 3 clk.
- Tile word fields:
  - fg = d[2:0], ordered {R,G,B}
  - bg = d[5:3], ordered {R,G,B}
  - blink = d[6]
  - pat = d[8:7]
- Pattern decode:
  - 00 = solid fg
  - 01 = checker: fg if lx[2]^ly[2], else bg
  - 10 = border: fg if lx∈{0,31} or ly∈{0,31}, else bg
  - 11 = solid bg
- Blink: if blink=1 and blink_phase=1, fg is replaced by bg before the pattern decode.
- Invalid pixel (valid=0 at S3): R=G=B=0.
- Blink timer:
  - frame_cnt increments on each vsync_in falling edge (1→0), detected against a registered copy of vsync_in.
  - When frame_cnt = BLINK_FRAMES-1 at an edge, it wraps to 0 and blink_phase toggles.
  - Simultaneous edge and wrap: wrap and toggle happen in the same cycle.
- Reset (asynchronous, reset=0), applied immediately:
  - R=G=B=0, hSync=vSync=SYNC_IDLE
  - all pipeline valid bits 0, all sync delay stages = SYNC_IDLE
  - mem_addr = BASE_ADDR, frame_cnt = 0, blink_phase = 0, previous-vsync register = SYNC_IDLE
- Reset mid-frame: on release, outputs follow the inputs after 3 clk, with no stale colour. The first frame after reset counts from frame_cnt = 0.
- No handshake to memory; memory is always ready and read-only from this block.

Decomposition:
- Package vga_pkg:
  - H_TILES=20, V_TILES=15, TILE_SHIFT=5, H_ACTIVE=640, V_ACTIVE=480
  - PAT_SOLID_FG=2'b00, PAT_CHECK=2'b01, PAT_BORDER=2'b10, PAT_SOLID_BG=2'b11
  - field bit positions for fg, bg, blink and pat
- One sub-module, vga_blink_timer: vsync edge detect, frame_cnt and blink_phase, parameterised by BLINK_FRAMES and SYNC_IDLE.

Test Plan:
- Reset held low, inputs toggling -> R=G=B=0, hSync=vSync=1, mem_addr=BASE_ADDR. Release, then active=1, col=0, row=0 -> mem_addr=BASE_ADDR one clk later, and R/G/B valid 3 clk after the inputs.
- col=639, row=479, active=1, BASE_ADDR=12'h100 -> mem_addr=12'h100+299=12'h22B. col=32, row=32 -> offset 21.
- mem_data=9'b00_0_000_101 (solid fg=R,B) -> R=1, G=0, B=1. With active=0 in the same flow -> R=G=B=0 exactly 3 clk later; hSync tracks hsync_in with a 3 clk delay.
- mem_data pattern 01, fg=3'b111, bg=3'b000; lx=4, ly=0 -> white. lx=4, ly=4 -> black. Pattern 10 at lx=0 -> fg, at lx=5, ly=5 -> bg.
- BLINK_FRAMES=2, blink=1, fg=3'b010, bg=3'b001, pat=00: apply 2 vsync falling edges -> output switches from G to B; after 2 more edges -> back to G.
- Assert reset mid-line with blink_phase=1 -> outputs clear immediately. After release, blink_phase=0 and the first valid pixel appears 3 clk after the inputs.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and tile-word helpers for the VGA tile renderer.
package vga_pkg;

    localparam int H_TILES    = 20;
    localparam int V_TILES    = 15;
    localparam int TILE_SHIFT = 5;
    localparam int H_ACTIVE   = H_TILES << TILE_SHIFT;
    localparam int V_ACTIVE   = V_TILES << TILE_SHIFT;

    localparam logic [1:0] PAT_SOLID_FG = 2'b00;
    localparam logic [1:0] PAT_CHECK    = 2'b01;
    localparam logic [1:0] PAT_BORDER   = 2'b10;
    localparam logic [1:0] PAT_SOLID_BG = 2'b11;

    localparam int FG_LSB    = 0;
    localparam int FG_MSB    = 2;
    localparam int BG_LSB    = 3;
    localparam int BG_MSB    = 5;
    localparam int BLINK_BIT = 6;
    localparam int PAT_LSB   = 7;
    localparam int PAT_MSB   = 8;

    // ty*20 + tx built from shifts; largest result is 299, so 9 bits suffice.
    function automatic logic [8:0] tile_offset(input logic [3:0] ty, input logic [4:0] tx);
        return {1'b0, ty, 4'b0000} + {3'b000, ty, 2'b00} + {4'b0000, tx};
    endfunction

    function automatic logic [2:0] decode_rgb(input logic [8:0] d,
                                              input logic [4:0] lx,
                                              input logic [4:0] ly,
                                              input logic       phase);
        logic [2:0] fg;
        logic [2:0] bg;
        logic [2:0] rgb;
        bg = d[BG_MSB:BG_LSB];
        fg = (d[BLINK_BIT] && phase) ? bg : d[FG_MSB:FG_LSB];
        case (d[PAT_MSB:PAT_LSB])
            PAT_SOLID_FG: rgb = fg;
            PAT_CHECK:    rgb = (lx[2] ^ ly[2]) ? fg : bg;
            PAT_BORDER:   rgb = (lx == 5'd0 || lx == 5'd31 || ly == 5'd0 || ly == 5'd31) ? fg : bg;
            default:      rgb = bg;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_blink_timer.sv
// Counts vsync falling edges and toggles the blink phase every BLINK_FRAMES frames.
module vga_blink_timer #(
    parameter int   BLINK_FRAMES = 30,
    parameter logic SYNC_IDLE    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync_in,
    output logic blink_phase
);

    localparam int              CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             r_vs_prev;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_phase;
    logic             w_fall;

    assign w_fall      = r_vs_prev & ~vsync_in;
    assign blink_phase = r_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vs_prev   <= SYNC_IDLE;
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_vs_prev <= vsync_in;
            if (w_fall) begin
                if (r_frame_cnt == LAST) begin
                    r_frame_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vga_tile_renderer.sv
// Three-stage tile renderer: address issue, tile-memory read, colour decode with
// hsync/vsync delayed to stay aligned with R/G/B.
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int               ADDR_W       = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int               BLINK_FRAMES = 30,
    parameter logic             SYNC_IDLE    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        col,
    input  logic [8:0]        row,
    input  logic              active,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [8:0]        mem_data,
    output logic              R,
    output logic              G,
    output logic              B,
    output logic              hSync,
    output logic              vSync
);

    logic              w_in_range;
    logic              w_blink_phase;

    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_v1;
    logic              r_v2;
    logic [4:0]        r_lx1;
    logic [4:0]        r_ly1;
    logic [4:0]        r_lx2;
    logic [4:0]        r_ly2;
    logic [2:0]        r_hs;
    logic [2:0]        r_vs;
    logic [2:0]        r_rgb;

    assign w_in_range = active && (col < 10'(H_ACTIVE)) && (row < 9'(V_ACTIVE));

    vga_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES),
        .SYNC_IDLE   (SYNC_IDLE)
    ) u_blink (
        .clk        (clk),
        .reset      (reset),
        .vsync_in   (vsync_in),
        .blink_phase(w_blink_phase)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_addr <= BASE_ADDR;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_lx1      <= '0;
            r_ly1      <= '0;
            r_lx2      <= '0;
            r_ly2      <= '0;
            r_hs       <= {3{SYNC_IDLE}};
            r_vs       <= {3{SYNC_IDLE}};
            r_rgb      <= 3'b000;
        end else begin
            // Off-screen pixels leave the address alone; only the valid bit drops.
            if (w_in_range) begin
                r_mem_addr <= BASE_ADDR + ADDR_W'(tile_offset(row[8:5], col[9:5]));
            end
            r_v1  <= w_in_range;
            r_lx1 <= col[4:0];
            r_ly1 <= row[4:0];
            r_v2  <= r_v1;
            r_lx2 <= r_lx1;
            r_ly2 <= r_ly1;
            r_hs  <= {r_hs[1:0], hsync_in};
            r_vs  <= {r_vs[1:0], vsync_in};
            r_rgb <= r_v2 ? decode_rgb(mem_data, r_lx2, r_ly2, w_blink_phase) : 3'b000;
        end
    end

    assign mem_addr = r_mem_addr;
    assign R        = r_rgb[2];
    assign G        = r_rgb[1];
    assign B        = r_rgb[0];
    assign hSync    = r_hs[2];
    assign vSync    = r_vs[2];

endmodule
